// File: rtl/tiny_proc_pkg.sv
// Shared opcodes, FSM states and HALT encoding
// for the tiny accumulator core.
package tiny_proc_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_SHL  = 4'h5,
      OP_SHR  = 4'h6,
      OP_ST   = 4'h7,
      OP_ADDI = 4'h8,
      OP_LI   = 4'h9,
      OP_LD   = 4'hA,
      OP_ANDI = 4'hB,
      OP_BEQZ = 4'hC,
      OP_BNEZ = 4'hD,
      OP_JMP  = 4'hE,
      OP_HALT = 4'hF
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALTED
   } state_t;

   // Opcode field of HALT; operand field is zero.
   localparam logic [3:0] HALT_ENC = 4'hF;

endpackage

// File: rtl/tiny_alu_n.sv
// Combinational accumulator ALU: next acc value
// for one opcode, plus the zero flag of the current acc.
module tiny_alu_n
   import tiny_proc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [3:0]        opc,
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] opnd,
   output logic [DATA_W-1:0] result,
   output logic              acc_zero
);

   assign acc_zero = (acc == '0);

   always_comb begin
      result = acc;
      unique case (opcode_t'(opc))
         OP_ADD:  result = acc + opnd;
         OP_SUB:  result = acc - opnd;
         OP_AND:  result = acc & opnd;
         OP_OR:   result = acc | opnd;
         OP_XOR:  result = acc ^ opnd;
         OP_SHL:  result = acc << 1;
         OP_SHR:  result = acc >> 1;
         OP_ADDI: result = acc + opnd;
         OP_LI:   result = opnd;
         OP_LD:   result = opnd;
         OP_ANDI: result = acc & opnd;
         default: result = acc;
      endcase
   end

endmodule

// File: rtl/tiny_acc_core.sv
// Parametrised accumulator core with program-load port,
// run/step/halt control and a data-memory debug port.
module tiny_acc_core
   import tiny_proc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OPR_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               prog_valid,
   output logic               prog_ready,
   input  logic [OPR_W-1:0]   prog_addr,
   input  logic [OPR_W+3:0]   prog_data,
   input  logic               start,
   input  logic               abort,
   input  logic               step_mode,
   input  logic               step,
   input  logic [OPR_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0]  dbg_data,
   output logic [OPR_W-1:0]   pc,
   output logic [DATA_W-1:0]  acc,
   output logic               busy,
   output logic               halted,
   output logic [CNT_W-1:0]   retired
);

   localparam int DEPTH = 1 << OPR_W;
   localparam logic [OPR_W+3:0] HALT_INST =
      {{OPR_W{1'b0}}, HALT_ENC};

   state_t state;
   logic [OPR_W+3:0]  imem [DEPTH];
   logic [DATA_W-1:0] dmem [DEPTH];

   logic [OPR_W+3:0]        inst;
   opcode_t                 opc;
   logic [OPR_W-1:0]        opr;
   logic [DATA_W+OPR_W-1:0] imm_w;
   logic [DATA_W-1:0]       opnd;
   logic [DATA_W-1:0]       alu_res;
   logic                    acc_zero;
   logic                    exec;
   logic                    taken;
   logic                    last;

   assign inst  = imem[pc];
   assign opc   = opcode_t'(inst[3:0]);
   assign opr   = inst[OPR_W+3:4];
   assign imm_w = {{DATA_W{opr[OPR_W-1]}}, opr};

   always_comb begin
      opnd = dmem[opr];
      if (opc == OP_ADDI || opc == OP_LI || opc == OP_ANDI)
         opnd = imm_w[DATA_W-1:0];
   end

   tiny_alu_n #(.DATA_W(DATA_W)) u_alu (
      .opc      (opc),
      .acc      (acc),
      .opnd     (opnd),
      .result   (alu_res),
      .acc_zero (acc_zero)
   );

   // Branches test acc as it was before this instruction.
   assign taken = (opc == OP_JMP)
               || (opc == OP_BEQZ && acc_zero)
               || (opc == OP_BNEZ && !acc_zero);
   assign last  = (pc == {OPR_W{1'b1}});
   assign exec  = (state == RUN) && (!step_mode || step);

   assign prog_ready = (state == IDLE);
   assign busy       = (state == RUN);
   assign halted     = (state == HALTED);
   assign dbg_data   = dmem[dbg_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pc      <= '0;
         acc     <= '0;
         retired <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            imem[i] <= HALT_INST;
            dmem[i] <= '0;
         end
      end else begin
         if (state == IDLE && prog_valid)
            imem[prog_addr] <= prog_data;
         if (abort) begin
            state <= IDLE;
         end else if (start && state != RUN) begin
            state   <= RUN;
            pc      <= '0;
            acc     <= '0;
            retired <= '0;
         end else if (exec) begin
            if (retired != {CNT_W{1'b1}})
               retired <= retired + CNT_W'(1);
            acc <= alu_res;
            if (opc == OP_ST)
               dmem[opr] <= acc;
            if (opc == OP_HALT)
               state <= HALTED;
            else if (taken)
               pc <= opr;
            else if (last)
               state <= HALTED;
            else
               pc <= pc + OPR_W'(1);
         end
      end
   end

endmodule
